rca_result_fifo: RTL and testbench
==================================

# rca_result_fifo

Downstream capture stage for the 16-bit ripple-carry adder datapath. Registers each adder result (sum, carry-out) with derived status flags into a small FIFO and hands the results to the consumer over a valid/ready handshake. Decouples the combinational adder from a consumer that may stall, and keeps a saturating count of signed-overflow results for debug.

## Interface
- `WIDTH`, 16: sum width in bits; `sum_in` and `out_sum` are this wide.
- `DEPTH`, 4: FIFO entries; a power of two, at least 2.
- `CW`, 8: width of the overflow counter.

Ports (direction, width, meaning):
- `clk`, in, 1: single clock; everything is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: adder result on `sum_in`/`cout_in` is valid.
- `in_ready`, out, 1: FIFO can accept an entry.
- `sum_in`, in, WIDTH: adder sum.
- `cout_in`, in, 1: adder carry-out.
- `a_msb`, in, 1: MSB of adder operand A, for overflow detection.
- `b_msb`, in, 1: MSB of adder operand B, for overflow detection.
- `out_valid`, out, 1: head entry is valid.
- `out_ready`, in, 1: consumer accepts the head entry.
- `out_sum`, out, WIDTH: head sum.
- `out_cout`, out, 1: head carry.
- `out_zero`, out, 1: head flag, sum == 0.
- `out_neg`, out, 1: head flag, sum[WIDTH-1].
- `out_ovf`, out, 1: head flag, signed overflow.
- `level`, out, log2(DEPTH)+1: number of occupied entries.
- `ovf_count`, out, CW: saturating count of accepted entries with `ovf` = 1.

## Operation
- **Push:** `in_valid && in_ready` on an edge.
  - Writes {sum_in, cout_in, zero, neg, ovf} to the entry at `wr_ptr`.
  - Advances `wr_ptr` modulo DEPTH.
- **Flags are computed at push time**, combinationally from the inputs:
  - zero = (sum_in == 0).
  - neg = sum_in[WIDTH-1].
  - ovf = (a_msb == b_msb) && (sum_in[WIDTH-1] != a_msb).
- **Pop:** `out_valid && out_ready` on an edge. Advances `rd_ptr` modulo DEPTH.
- **Occupancy:** `level` increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
- **Ready/valid:**
  - `in_ready` = (level != DEPTH). It depends only on state, never on `out_ready`.
  - `out_valid` = (level != 0).
- **Output data:**
  - `out_sum`, `out_cout`, `out_zero`, `out_neg` and `out_ovf` show the entry at `rd_ptr` when `out_valid` = 1.
  - All of them are forced to 0 when `out_valid` = 0.
- **Overflow counter:** `ovf_count` increments on each push whose ovf = 1 and saturates at 2^CW-1. Pops do not affect it.
- **Full:** `in_ready` = 0, so `in_valid` is ignored. This holds even if `out_ready` = 1 in the same cycle, so there is no push-through when full.
- **Empty:** `out_ready` is ignored. A push into an empty FIFO is not bypassed to the outputs.
- **Pointer wrap:** pointers wrap from DEPTH-1 to 0 with no gap, so the full/empty decision comes from `level`, not from pointer compare.
- **Reset:**
  - `rst` = 1 forces `wr_ptr` = `rd_ptr` = 0, `level` = 0 and `ovf_count` = 0.
  - After an edge with `rst` = 1: `out_valid` = 0, `in_ready` = 1, and all data/flag outputs are 0.
  - Reset has priority over a simultaneous push or pop, and in-flight entries are discarded.
  - Storage contents need not be reset.

## Timing
- **Latency:** a push on edge N makes the entry visible, with `out_valid` = 1, after edge N when the FIFO was empty.
- **Throughput:** one push and one pop per cycle, sustained, when 0 < level < DEPTH.
- **`in_ready`:** changes only after an edge. It reaches 0 on the edge that makes `level` = DEPTH, and returns to 1 on the edge of the first pop.
- **`out_valid`:** stays 1 while the consumer stalls (`out_ready` = 0). Head data is held stable until popped.
- **Input stability:** `sum_in`, `cout_in`, `a_msb` and `b_msb` are sampled only on a push edge. They may change freely otherwise.

## Test plan
- **Single result.** After reset, push sum_in = 16'h0000, cout_in = 1, a_msb = 1, b_msb = 1 (0x8000 + 0x8000). The cycle after, expect out_valid = 1, out_sum = 0, out_cout = 1, out_zero = 1, out_neg = 0, out_ovf = 1, ovf_count = 1, level = 1.
- **Fill and stall.** Hold out_ready = 0 and push 0x0001, 0x0002, 0x0003, 0x0004. Expect level = 4 and in_ready = 0. A 5th push of 0x0005 is ignored. Then pop with out_ready = 1 for 4 cycles: expect 0x0001..0x0004 in order, then out_valid = 0 and all outputs 0.
- **Streaming with wrap.** Push and pop every cycle for 10 results, 0x7FFF then 0x8000 alternating. Expect level stays at 1 after the first cycle, order is preserved across the pointer wrap, and out_neg alternates 0/1.
- **Overflow saturation.** With CW = 8, push 300 results with a_msb = 0, b_msb = 0, sum_in[15] = 1. Expect ovf_count = 255 and no wrap. Results with a_msb ≠ b_msb must never increment it.
- **Boundary events.**
  - Full plus out_ready = 1 plus in_valid = 1 in one cycle: exactly one pop, no push, level = 3.
  - Empty plus push: no same-cycle output.
- **Mid-operation reset.** With level = 3, assert rst for 1 cycle together with in_valid = 1. Expect level = 0, out_valid = 0, in_ready = 1, ovf_count = 0, and the pushed value discarded.

Source files
------------

// File: rtl/rca_result_fifo.sv
// rca_result_fifo: result capture FIFO behind the 16-bit ripple-carry adder.
// Registers {sum, cout, zero, neg, ovf} per push and serves them over valid/ready.
//
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   in_valid / in_ready          : producer handshake (adder side)
//   sum_in, cout_in              : adder result
//   a_msb, b_msb                 : operand MSBs for signed-overflow detection
//   out_valid / out_ready        : consumer handshake
//   out_sum, out_cout            : head result (0 when empty)
//   out_zero, out_neg, out_ovf   : head flags (0 when empty)
//   level                        : occupied entries
//   ovf_count                    : saturating count of pushed overflow results
module rca_result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         sum_in,
    input  logic                     cout_in,
    input  logic                     a_msb,
    input  logic                     b_msb,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_sum,
    output logic                     out_cout,
    output logic                     out_zero,
    output logic                     out_neg,
    output logic                     out_ovf,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CW-1:0]            ovf_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = WIDTH + 4;

    // Entry layout: {sum, cout, zero, neg, ovf}
    logic [EW-1:0]    mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [EW-1:0]    head;
    logic             push;
    logic             pop;
    logic             zero;
    logic             neg;
    logic             ovf;

    assign zero = (sum_in == '0);
    assign neg  = sum_in[WIDTH-1];
    // Same-sign operands producing an opposite-sign result.
    assign ovf  = (a_msb == b_msb) && (sum_in[WIDTH-1] != a_msb);

    // Full/empty come from level so pointers can wrap freely.
    assign in_ready  = (level != LW'(DEPTH));
    assign out_valid = (level != '0);

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    assign head = mem[rd_ptr];
    assign {out_sum, out_cout, out_zero, out_neg, out_ovf} =
        out_valid ? head : '0;

    // Storage is not reset; level gates everything that reads it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {sum_in, cout_in, zero, neg, ovf};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            ovf_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (push && ovf && (ovf_count != '1)) begin
                ovf_count <= ovf_count + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_rca_result_fifo.sv
// tb_rca_result_fifo: directed and random checks of rca_result_fifo
// against a queue-based reference model.
module tb_rca_result_fifo;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int CW = 8;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  sum_in;
    logic          cout_in;
    logic          a_msb;
    logic          b_msb;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          out_zero;
    logic          out_neg;
    logic          out_ovf;
    logic [2:0]    level;
    logic [CW-1:0] ovf_count;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } ent_t;

    ent_t q[$];
    int   m_cnt = 0;

    always #5 clk = ~clk;

    rca_result_fifo #(.WIDTH(W), .DEPTH(D), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .cout_in   (cout_in),
        .a_msb     (a_msb),
        .b_msb     (b_msb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .out_ovf   (out_ovf),
        .level     (level),
        .ovf_count (ovf_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the model.
    task automatic check_all(input string tag);
        logic [W-1:0] es;
        logic         ec, ez, en, eo, ev;
        ev = (q.size() != 0);
        es = ev ? q[0].sum : '0;
        ec = ev ? q[0].cout : 1'b0;
        eo = ev ? q[0].ovf : 1'b0;
        ez = ev && (int'(es) == 0);
        en = ev && (int'(es) >= (1 << (W - 1)));
        chk({tag, ".level"}, 32'(level), 32'(q.size()));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() != D));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, ".out_sum"}, 32'(out_sum), 32'(es));
        chk({tag, ".out_cout"}, 32'(out_cout), 32'(ec));
        chk({tag, ".out_zero"}, 32'(out_zero), 32'(ez));
        chk({tag, ".out_neg"}, 32'(out_neg), 32'(en));
        chk({tag, ".out_ovf"}, 32'(out_ovf), 32'(eo));
        chk({tag, ".ovf_count"}, 32'(ovf_count), 32'(m_cnt));
    endtask

    // One clock: model decides push/pop from pre-edge state, then
    // outputs are checked 1 time unit after the edge.
    task automatic cycle(input string tag);
        bit   do_push, do_pop;
        ent_t e;
        do_push = in_valid && (q.size() < D);
        do_pop  = out_ready && (q.size() > 0);
        e.sum  = sum_in;
        e.cout = cout_in;
        e.ovf  = (a_msb == b_msb) && (sum_in[W-1] != a_msb);
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_cnt = 0;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back(e);
                if (e.ovf && m_cnt < SAT) m_cnt++;
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic [W-1:0] s, input logic c,
                         input logic a, input logic b);
        sum_in  = s;
        cout_in = c;
        a_msb   = a;
        b_msb   = b;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive('0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        cycle("reset");
        cycle("reset2");
        rst = 1'b0;

        // Single result: 0x8000 + 0x8000
        drive(16'h0000, 1'b1, 1'b1, 1'b1);
        in_valid = 1'b1;
        cycle("single");
        in_valid = 1'b0;
        chk("single.sum", 32'(out_sum), 32'h0);
        chk("single.zero", 32'(out_zero), 32'd1);
        chk("single.ovf", 32'(out_ovf), 32'd1);
        chk("single.cnt", 32'(ovf_count), 32'd1);
        out_ready = 1'b1;
        cycle("single_pop");

        // Fill and stall
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            drive(W'(i), 1'b0, 1'b0, 1'b0);
            cycle("fill");
        end
        chk("fill.level", 32'(level), 32'd4);
        chk("fill.in_ready", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain.head", 32'(out_sum), 32'(i));
            cycle("drain");
        end
        chk("drain.valid", 32'(out_valid), 32'd0);

        // Streaming with pointer wrap
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive((i % 2) ? 16'h8000 : 16'h7FFF, 1'b0, 1'b0, 1'b1);
            cycle("stream");
            chk("stream.level", 32'(level), 32'd1);
            chk("stream.neg", 32'(out_neg), 32'(i % 2));
        end
        in_valid = 1'b0;
        cycle("stream_end");

        // Overflow saturation
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            drive(16'h8000 | W'($urandom_range(0, 16'h7FFF)),
                  1'(($urandom)), 1'b0, 1'b0);
            cycle("sat");
        end
        chk("sat.cnt", 32'(ovf_count), 32'(SAT));
        for (int i = 0; i < 20; i++) begin
            drive(W'($urandom), 1'(($urandom)), 1'b1, 1'b0);
            cycle("sat_mixed");
        end
        chk("sat.hold", 32'(ovf_count), 32'(SAT));
        in_valid = 1'b0;
        cycle("sat_end");

        // Full + pop + push: exactly one pop
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(W'(16'h100 + i), 1'b0, 1'b0, 1'b0);
            cycle("bfill");
        end
        out_ready = 1'b1;
        drive(16'hBEEF, 1'b1, 1'b0, 1'b0);
        cycle("full_pop");
        chk("full_pop.level", 32'(level), 32'd3);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle("bdrain");

        // Empty + push: nothing appears in the same cycle
        in_valid = 1'b1;
        drive(16'h1234, 1'b0, 1'b0, 1'b0);
        #1;
        chk("empty.nobypass", 32'(out_valid), 32'd0);
        chk("empty.nosum", 32'(out_sum), 32'd0);
        cycle("empty_push");
        in_valid = 1'b0;
        cycle("empty_pop");

        // Mid-operation reset with a concurrent push
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(W'(16'h4000 + i), 1'b0, 1'b1, 1'b1);
            cycle("pre_rst");
        end
        rst = 1'b1;
        drive(16'h5555, 1'b1, 1'b0, 1'b0);
        cycle("mid_rst");
        chk("mid_rst.level", 32'(level), 32'd0);
        chk("mid_rst.cnt", 32'(ovf_count), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        cycle("post_rst");

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'(($urandom_range(0, 3) != 0));
            out_ready = 1'(($urandom_range(0, 2) != 0));
            drive(W'($urandom), 1'(($urandom)), 1'(($urandom)),
                  1'(($urandom)));
            cycle("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
